// File: rtl/sortof_pkg.sv
// Shared sortof constants, assembly state encoding and word metadata.
// Used by the chunk reassembly stage and its output holding register.
package sortof_pkg;

  localparam int CHUNK_SIZE_BITS = 4;
  localparam int NUM_CHUNKS      = 8;
  localparam int DATA_SIZE_BITS  = NUM_CHUNKS * CHUNK_SIZE_BITS;
  localparam int CNT_BITS        = $clog2(NUM_CHUNKS + 1);
  localparam int META_BITS       = CNT_BITS + 1;

  typedef enum logic {
    FILL = 1'b0,
    HELD = 1'b1
  } asm_state_e;

  typedef struct packed {
    logic [CNT_BITS-1:0] count;
    logic                partial;
  } word_meta_t;

endpackage

// File: rtl/out_word_reg.sv
// One-entry valid/ready holding register.
// A load on the same edge as a drain keeps valid high and takes the new word.
module out_word_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain && valid) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/in_chunks.sv
// Reassembles a stream of chunks into full-width words for the sorter core.
// Assembly register (p0) feeds an output holding register (p1) so assembly overlaps drain.
module in_chunks
  import sortof_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [CHUNK_SIZE_BITS-1:0] in_bits,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [DATA_SIZE_BITS-1:0]  word_data,
  output logic [CNT_BITS-1:0]        word_count,
  output logic                       word_partial
);

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NUM_CHUNKS - 1);
  localparam int                  OUT_W    = DATA_SIZE_BITS + META_BITS;

  asm_state_e                state_q, state_d;
  logic [CNT_BITS-1:0]       idx_p0;
  logic [DATA_SIZE_BITS-1:0] asm_data_p0;
  word_meta_t                asm_meta_p0;

  logic                      accept;
  logic                      close;
  logic                      out_free;
  logic                      load;
  logic [DATA_SIZE_BITS-1:0] asm_next;
  word_meta_t                new_meta;
  logic [OUT_W-1:0]          load_word;
  logic [OUT_W-1:0]          out_word;
  word_meta_t                out_meta;

  always_comb begin
    in_ready = (state_q == FILL);
    accept   = in_valid && in_ready;
    close    = accept && (in_last || (idx_p0 == LAST_IDX));
    out_free = !word_valid || word_ready;

    // Index 0 starts a fresh word so unfilled upper chunks of a short word read as zero.
    asm_next = (idx_p0 == '0) ? '0 : asm_data_p0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (int'(idx_p0) == k) asm_next[k*CHUNK_SIZE_BITS +: CHUNK_SIZE_BITS] = in_bits;
    end

    new_meta.count   = idx_p0 + CNT_BITS'(1);
    new_meta.partial = (idx_p0 != LAST_IDX);

    state_d   = state_q;
    load      = 1'b0;
    load_word = {asm_data_p0, asm_meta_p0};
    case (state_q)
      FILL: begin
        if (close) begin
          if (out_free) begin
            load      = 1'b1;
            load_word = {asm_next, new_meta};
          end else begin
            state_d = HELD;
          end
        end
      end
      HELD: begin
        if (word_ready && word_valid) begin
          load    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FILL;
    else          state_q <= state_d;
  end

  // p0: assembly register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_p0      <= '0;
      asm_data_p0 <= '0;
      asm_meta_p0 <= '0;
    end else if (accept) begin
      asm_data_p0 <= asm_next;
      idx_p0      <= close ? '0 : idx_p0 + CNT_BITS'(1);
      if (close) asm_meta_p0 <= new_meta;
    end
  end

  // p1: output holding register
  out_word_reg #(
    .W (OUT_W)
  ) u_out_word_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_word),
    .drain     (word_ready),
    .valid     (word_valid),
    .data      (out_word)
  );

  assign {word_data, out_meta} = out_word;
  assign word_count            = out_meta.count;
  assign word_partial          = out_meta.partial;

endmodule

// File: tb/tb_in_chunks.sv
// Directed bench for in_chunks: packing, backpressure, partial words, overlap and async reset.
module tb_in_chunks;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [3:0]  in_bits;
  logic        in_last;
  logic        in_ready;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [3:0]  word_count;
  logic        word_partial;

  int total = 0;
  int bad   = 0;

  logic [3:0] wa [8] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hd, 4'hc, 4'hb, 4'ha};
  logic [3:0] wb [8] = '{4'hf, 4'he, 4'hd, 4'hc, 4'hb, 4'ha, 4'h9, 4'h8};

  always #5 clk = ~clk;

  in_chunks dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_bits      (in_bits),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_data    (word_data),
    .word_count   (word_count),
    .word_partial (word_partial)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic last);
    in_valid = 1'b1;
    in_bits  = c;
    in_last  = last;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] cnt,
                          input logic part);
    chk({tag, "_valid"}, 32'(word_valid), 32'd1);
    chk({tag, "_data"}, word_data, d);
    chk({tag, "_count"}, 32'(word_count), 32'(cnt));
    chk({tag, "_partial"}, 32'(word_partial), 32'(part));
  endtask

  initial begin
    reset_n    = 1'b1;
    in_valid   = 1'b0;
    in_bits    = 4'h0;
    in_last    = 1'b0;
    word_ready = 1'b0;
    #3 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_data", word_data, 32'h0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_word_partial", 32'(word_partial), 32'd0);
    reset_n = 1'b1;
    tick();

    // Full word, no stall
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(wa[i], 1'b0);
      if (i == 6) chk("full_early_valid", 32'(word_valid), 32'd0);
    end
    chk_word("full", 32'habcd1234, 4'd8, 1'b0);
    idle();
    tick();
    chk("full_one_cycle", 32'(word_valid), 32'd0);

    // Backpressure with two full words
    word_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send((i < 8) ? wa[i] : wb[i-8], 1'b0);
      if (i == 7) begin
        chk_word("bp_first", 32'habcd1234, 4'd8, 1'b0);
        chk("bp_ready_mid", 32'(in_ready), 32'd1);
      end
    end
    idle();
    chk("bp_ready_drop", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk_word("bp_hold", 32'habcd1234, 4'd8, 1'b0);
    chk("bp_ready_held", 32'(in_ready), 32'd0);
    word_ready = 1'b1;
    tick();
    chk_word("bp_second", 32'h89abcdef, 4'd8, 1'b0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drained", 32'(word_valid), 32'd0);

    // Partial words, single-chunk words, ignored in_last and mid-word pause
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b1);
    chk_word("partial3", 32'h00000765, 4'd3, 1'b1);
    send(4'h9, 1'b1);
    chk_word("partial_next", 32'h00000009, 4'd1, 1'b1);
    send(4'hf, 1'b1);
    chk_word("single", 32'h0000000f, 4'd1, 1'b1);
    idle();
    in_last = 1'b1;
    tick();
    tick();
    chk("last_no_valid", 32'(word_valid), 32'd0);
    in_last = 1'b0;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    idle();
    tick();
    tick();
    tick();
    chk("pause_no_word", 32'(word_valid), 32'd0);
    for (int i = 3; i <= 8; i++) send(4'(i), (i == 8));
    chk_word("pause_full_last", 32'h87654321, 4'd8, 1'b0);
    idle();
    tick();

    // Simultaneous drain and load
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(wa[i], 1'b0);
    chk_word("sim_first", 32'habcd1234, 4'd8, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send(wb[i], 1'b0);
      chk("sim_in_ready", 32'(in_ready), 32'd1);
    end
    chk("sim_stable", word_data, 32'habcd1234);
    word_ready = 1'b1;
    send(wb[7], 1'b0);
    chk_word("sim_second", 32'h89abcdef, 4'd8, 1'b0);
    chk("sim_in_ready_end", 32'(in_ready), 32'd1);
    idle();
    tick();
    chk("sim_drained", 32'(word_valid), 32'd0);

    // Asynchronous reset mid-word
    for (int i = 0; i < 5; i++) send(wa[i], 1'b0);
    idle();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_valid", 32'(word_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) send(wa[i], 1'b0);
    chk_word("rst_mid_fresh", 32'habcd1234, 4'd8, 1'b0);
    idle();
    tick();

    // Asynchronous reset while HELD
    word_ready = 1'b0;
    for (int i = 0; i < 16; i++) send((i < 8) ? wa[i] : wb[i-8], 1'b0);
    idle();
    chk("held_ready", 32'(in_ready), 32'd0);
    chk_word("held_out", 32'habcd1234, 4'd8, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_held_valid", 32'(word_valid), 32'd0);
    chk("rst_held_data", word_data, 32'h0);
    chk("rst_held_count", 32'(word_count), 32'd0);
    chk("rst_held_partial", 32'(word_partial), 32'd0);
    chk("rst_held_ready", 32'(in_ready), 32'd1);
    tick();
    reset_n    = 1'b1;
    word_ready = 1'b1;
    tick();
    chk("rst_held_no_residue", 32'(word_valid), 32'd0);
    for (int i = 0; i < 8; i++) send(wb[i], 1'b0);
    chk_word("rst_held_fresh", 32'h89abcdef, 4'd8, 1'b0);
    idle();
    tick();
    chk("rst_held_end", 32'(word_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
